// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state encoding, instruction constants and reset PC
// for the instruction fetch stage.
package ifetch_pkg;

    localparam logic ENC_WAIT  = 1'b0;
    localparam logic ENC_READY = 1'b1;

    typedef enum logic {
        S_WAIT  = ENC_WAIT,
        S_READY = ENC_READY
    } state_t;

    localparam logic [15:0] INSTR_NOP  = 16'h0000;
    localparam logic [15:0] INSTR_HALT = 16'h0300;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/ifetch_latency_ctr.sv
// ifetch_latency_ctr: counts memory read latency after a (re)start.
// The primed bit covers the memory's own address-capture edge.
module ifetch_latency_ctr #(
    parameter int MEM_LATENCY = 1
) (
    input  logic clock,
    input  logic resetn,
    input  logic start,
    output logic done
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    logic          primed;
    logic [CW-1:0] cnt;

    assign done = primed && (cnt == CW'(MEM_LATENCY - 1));

    always_ff @(posedge clock) begin
        if (!resetn || start) begin
            primed <= 1'b0;
            cnt    <= '0;
        end else if (!primed) begin
            primed <= 1'b1;
        end else if (!done) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, WAIT/READY fetch FSM, instruction latch.
// Define IFETCH_PREFETCH_EN for a 1-entry zero-bubble PC+1 prefetch buffer.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                MEM_LATENCY = 1,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pc_increment,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_value,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       current_instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] program_counter,
    output logic              fetch_overrun
);

    state_t            state;
    logic              in_ready;
    logic              req;
    logic              fetch_start;
    logic              fetch_done;
    logic              zero_bubble;
    logic [15:0]       bubble_instr;
    logic [ADDR_W-1:0] pc_next_seq;

    assign in_ready    = (state == S_READY);
    assign req         = pc_increment | pc_load;
    assign pc_next_seq = program_counter + ADDR_W'(1);
    assign fetch_start = in_ready & req & ~zero_bubble;

    ifetch_latency_ctr #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_fetch_ctr (
        .clock (clock),
        .resetn(resetn),
        .start (fetch_start),
        .done  (fetch_done)
    );

`ifdef IFETCH_PREFETCH_EN
    logic        pvalid;
    logic        prefetching;
    logic        pf_done;
    logic        pf_start;
    logic [15:0] pbuf;

    assign prefetching  = in_ready & ~pvalid;
    assign pf_start     = ~prefetching | zero_bubble;
    // A prefetch completing this very cycle is as good as a full buffer.
    assign zero_bubble  = in_ready & pc_increment & ~pc_load
                        & (pvalid | (prefetching & pf_done));
    assign bubble_instr = pvalid ? pbuf : imem_rdata;
    assign imem_addr    = prefetching ? pc_next_seq : program_counter;

    ifetch_latency_ctr #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_pf_ctr (
        .clock (clock),
        .resetn(resetn),
        .start (pf_start),
        .done  (pf_done)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pvalid <= 1'b0;
            pbuf   <= INSTR_NOP;
        end else if (in_ready & req) begin
            pvalid <= 1'b0;
        end else if (prefetching & pf_done) begin
            pvalid <= 1'b1;
            pbuf   <= imem_rdata;
        end
    end
`else
    assign zero_bubble  = 1'b0;
    assign bubble_instr = INSTR_NOP;
    assign imem_addr    = program_counter;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state               <= S_WAIT;
            program_counter     <= RESET_PC;
            current_instruction <= INSTR_NOP;
            instr_valid         <= 1'b0;
            fetch_overrun       <= 1'b0;
        end else begin
            fetch_overrun <= ~in_ready & req;
            unique case (state)
                S_WAIT: begin
                    if (fetch_done) begin
                        current_instruction <= imem_rdata;
                        instr_valid         <= 1'b1;
                        state               <= S_READY;
                    end
                end
                S_READY: begin
                    if (pc_load) begin
                        program_counter <= pc_load_value;
                        instr_valid     <= 1'b0;
                        state           <= S_WAIT;
                    end else if (pc_increment) begin
                        program_counter <= pc_next_seq;
                        if (zero_bubble) begin
                            current_instruction <= bubble_instr;
                        end else begin
                            instr_valid <= 1'b0;
                            state       <= S_WAIT;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized run against a
// timestamp-based reference model, for MEM_LATENCY=1 and MEM_LATENCY=3.
module tb_instruction_fetch;

`ifdef IFETCH_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    localparam int BIG = 32'h7fff_ffff;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        valid;
        logic        ovr;
        int          ready_at;
        int          pf_at;
    } mdl_t;

    logic        clock = 1'b0;
    logic        resetn;
    logic        pc_increment;
    logic        pc_load;
    logic [15:0] pc_load_value;

    logic [15:0] a1, r1, i1, p1;
    logic        v1, o1;
    logic [15:0] a3, r3, i3, p3;
    logic        v3, o3;

    logic [15:0] mem1_q;
    logic [15:0] mem3_q [3];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    mdl_t m1, m3;

    always #5 clock = ~clock;

    instruction_fetch #(.ADDR_W(16), .MEM_LATENCY(1)) dut1 (
        .clock(clock), .resetn(resetn),
        .pc_increment(pc_increment), .pc_load(pc_load),
        .pc_load_value(pc_load_value), .imem_addr(a1), .imem_rdata(r1),
        .current_instruction(i1), .instr_valid(v1),
        .program_counter(p1), .fetch_overrun(o1)
    );

    instruction_fetch #(.ADDR_W(16), .MEM_LATENCY(3)) dut3 (
        .clock(clock), .resetn(resetn),
        .pc_increment(pc_increment), .pc_load(pc_load),
        .pc_load_value(pc_load_value), .imem_addr(a3), .imem_rdata(r3),
        .current_instruction(i3), .instr_valid(v3),
        .program_counter(p3), .fetch_overrun(o3)
    );

    // Synchronous memories with 1 and 3 register stages; data = addr ^ A5A5.
    always @(posedge clock) begin
        mem1_q    <= a1 ^ 16'hA5A5;
        mem3_q[0] <= a3 ^ 16'hA5A5;
        mem3_q[1] <= mem3_q[0];
        mem3_q[2] <= mem3_q[1];
    end
    assign r1 = mem1_q;
    assign r3 = mem3_q[2];

    // Reference: a fetch issued at edge c delivers its word at edge c+lat+1.
    function automatic mdl_t step(mdl_t m, int lat, logic rst, logic inc,
                                  logic ld, logic [15:0] val, int c);
        mdl_t n = m;
        n.ovr = 1'b0;
        if (!rst) begin
            n.pc = 16'h0000; n.instr = 16'h0000; n.valid = 1'b0;
            n.ready_at = c + lat + 1; n.pf_at = BIG;
        end else if (!m.valid) begin
            n.ovr = inc | ld;
            if (c == m.ready_at) begin
                n.instr = m.pc ^ 16'hA5A5;
                n.valid = 1'b1;
                n.pf_at = c + lat + 1;
            end
        end else if (ld | inc) begin
            n.pc = ld ? val : m.pc + 16'd1;
            if (!ld && PF && c >= m.pf_at) begin
                n.instr = n.pc ^ 16'hA5A5;
                n.pf_at = c + lat + 1;
            end else begin
                n.valid = 1'b0;
                n.ready_at = c + lat + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] exp_addr(mdl_t m, int c);
        return (PF && m.valid && (c - 1) < m.pf_at) ? m.pc + 16'd1 : m.pc;
    endfunction

    always @(posedge clock) begin
        m1  <= step(m1, 1, resetn, pc_increment, pc_load, pc_load_value, cyc);
        m3  <= step(m3, 3, resetn, pc_increment, pc_load, pc_load_value, cyc);
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; pc_increment = 1'b0; pc_load = 1'b0;
        pc_load_value = 16'h0000;
        tick(); tick();
        checks++;
        if (p1 !== 16'h0000) begin
            failures++; $display("FAIL reset_pc: got %h want 0000", p1);
        end
        checks++;
        if (i1 !== 16'h0000) begin
            failures++; $display("FAIL reset_instr: got %h want 0000", i1);
        end
        checks++;
        if (v1 !== 1'b0 || o1 !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got v=%b o=%b want 0 0", v1, o1);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (v1 !== 1'b0) begin
            failures++; $display("FAIL reset_early_valid: got %b want 0", v1);
        end
        tick();
        checks++;
        if (v1 !== 1'b1 || i1 !== 16'hA5A5 || p1 !== 16'h0000) begin
            failures++;
            $display("FAIL first_fetch: got v=%b i=%h pc=%h want 1 A5A5 0000", v1, i1, p1);
        end
    endtask

    task automatic test_increment();
        pc_load = 1'b1; pc_load_value = 16'h0005;
        tick();
        pc_load = 1'b0;
        tick(); tick();
        checks++;
        if (v1 !== 1'b1 || p1 !== 16'h0005 || i1 !== 16'hA5A0) begin
            failures++;
            $display("FAIL load5: got v=%b pc=%h i=%h want 1 0005 A5A0", v1, p1, i1);
        end
        pc_increment = 1'b1;
        tick();
        pc_increment = 1'b0;
        checks++;
        if (p1 !== 16'h0006 || v1 !== 1'b0) begin
            failures++; $display("FAIL inc_pc: got pc=%h v=%b want 0006 0", p1, v1);
        end
        tick();
        checks++;
        if (v1 !== 1'b0) begin
            failures++; $display("FAIL inc_bubble2: got %b want 0", v1);
        end
        tick();
        checks++;
        if (v1 !== 1'b1 || i1 !== 16'hA5A3) begin
            failures++; $display("FAIL inc_instr: got v=%b i=%h want 1 A5A3", v1, i1);
        end
    endtask

    task automatic test_load_priority();
        pc_load = 1'b1; pc_increment = 1'b1; pc_load_value = 16'h0040;
        tick();
        pc_load = 1'b0; pc_increment = 1'b0;
        checks++;
        if (p1 !== 16'h0040 || v1 !== 1'b0) begin
            failures++; $display("FAIL load_wins: got pc=%h v=%b want 0040 0", p1, v1);
        end
        tick(); tick();
        checks++;
        if (v1 !== 1'b1 || i1 !== 16'hA5E5) begin
            failures++; $display("FAIL load_instr: got v=%b i=%h want 1 A5E5", v1, i1);
        end
    endtask

    task automatic test_wrap();
        pc_load = 1'b1; pc_load_value = 16'hFFFF;
        tick();
        pc_load = 1'b0;
        tick(); tick();
        pc_increment = 1'b1;
        tick();
        pc_increment = 1'b0;
        checks++;
        if (p1 !== 16'h0000) begin
            failures++; $display("FAIL wrap_pc: got %h want 0000", p1);
        end
        tick(); tick();
        checks++;
        if (v1 !== 1'b1 || i1 !== 16'hA5A5) begin
            failures++; $display("FAIL wrap_instr: got v=%b i=%h want 1 A5A5", v1, i1);
        end
    endtask

    task automatic test_overrun();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        pc_increment = 1'b1;
        tick();
        pc_increment = 1'b0;
        checks++;
        if (o3 !== 1'b1 || p3 !== 16'h0000 || v3 !== 1'b0) begin
            failures++;
            $display("FAIL overrun_pulse: got o=%b pc=%h v=%b want 1 0000 0", o3, p3, v3);
        end
        tick();
        checks++;
        if (o3 !== 1'b0 || v3 !== 1'b0) begin
            failures++; $display("FAIL overrun_once: got o=%b v=%b want 0 0", o3, v3);
        end
        tick();
        checks++;
        if (v3 !== 1'b1 || i3 !== 16'hA5A5 || p3 !== 16'h0000) begin
            failures++;
            $display("FAIL lat3_fetch: got v=%b i=%h pc=%h want 1 A5A5 0000", v3, i3, p3);
        end
        pc_load = 1'b1; pc_load_value = 16'h0123;
        tick();
        pc_load = 1'b0;
        tick();
        checks++;
        if (p3 !== 16'h0123 || v3 !== 1'b0) begin
            failures++; $display("FAIL lat3_load: got pc=%h v=%b want 0123 0", p3, v3);
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++;
        if (p3 !== 16'h0000 || v3 !== 1'b0 || i3 !== 16'h0000) begin
            failures++;
            $display("FAIL midwait_reset: got pc=%h v=%b i=%h want 0000 0 0000", p3, v3, i3);
        end
        tick(); tick(); tick();
        checks++;
        if (v3 !== 1'b0) begin
            failures++; $display("FAIL refetch_early: got %b want 0", v3);
        end
        tick();
        checks++;
        if (v3 !== 1'b1 || i3 !== 16'hA5A5) begin
            failures++; $display("FAIL refetch: got v=%b i=%h want 1 A5A5", v3, i3);
        end
    endtask

    task automatic test_prefetch();
        logic [15:0] e_pc, e_i;
        logic        e_v, e_o;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick(); tick();
        tick();
        pc_increment = 1'b1;
        tick();
        pc_increment = 1'b0;
        e_v = PF;
        checks++;
        if (v1 !== e_v || p1 !== 16'h0001) begin
            failures++;
            $display("FAIL pf_inc1: got v=%b pc=%h want %b 0001", v1, p1, e_v);
        end
        tick();
        checks++;
        if (v1 !== e_v) begin
            failures++; $display("FAIL pf_gap: got v=%b want %b", v1, e_v);
        end
        pc_increment = 1'b1;
        tick();
        pc_increment = 1'b0;
        e_pc = PF ? 16'h0002 : 16'h0001;
        e_i  = PF ? 16'hA5A7 : 16'hA5A4;
        e_o  = !PF;
        checks++;
        if (v1 !== 1'b1 || p1 !== e_pc || i1 !== e_i || o1 !== e_o) begin
            failures++;
            $display("FAIL pf_inc2: got v=%b pc=%h i=%h o=%b want 1 %h %h %b",
                     v1, p1, i1, o1, e_pc, e_i, e_o);
        end
    endtask

    task automatic test_random();
        resetn = 1'b0; pc_increment = 1'b0; pc_load = 1'b0;
        tick();
        resetn = 1'b1;
        for (int n = 0; n < 600; n++) begin
            resetn        = ($urandom_range(99) != 0);
            pc_increment  = ($urandom_range(2) == 0);
            pc_load       = ($urandom_range(7) == 0);
            pc_load_value = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
            tick();
            checks++;
            if (p1 !== m1.pc || i1 !== m1.instr || v1 !== m1.valid
                || o1 !== m1.ovr || a1 !== exp_addr(m1, cyc)) begin
                failures++;
                $display("FAIL rand_lat1 n=%0d: got pc=%h i=%h v=%b o=%b a=%h want %h %h %b %b %h",
                         n, p1, i1, v1, o1, a1,
                         m1.pc, m1.instr, m1.valid, m1.ovr, exp_addr(m1, cyc));
            end
            checks++;
            if (p3 !== m3.pc || i3 !== m3.instr || v3 !== m3.valid
                || o3 !== m3.ovr || a3 !== exp_addr(m3, cyc)) begin
                failures++;
                $display("FAIL rand_lat3 n=%0d: got pc=%h i=%h v=%b o=%b a=%h want %h %h %b %b %h",
                         n, p3, i3, v3, o3, a3,
                         m3.pc, m3.instr, m3.valid, m3.ovr, exp_addr(m3, cyc));
            end
        end
        pc_increment = 1'b0; pc_load = 1'b0; resetn = 1'b1;
    endtask

    initial begin
        m1.valid = 1'b0; m1.ready_at = BIG; m1.pf_at = BIG;
        m3.valid = 1'b0; m3.ready_at = BIG; m3.pf_at = BIG;
        test_reset();
        test_increment();
        test_load_priority();
        test_wrap();
        test_overrun();
        test_prefetch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
